// File: rtl/ahb_sram_subordinate.sv
// AHB-Lite subordinate in front of a word-organised on-chip SRAM.
// It handles byte, halfword and word transfers with a fixed number of wait
// states. Illegal accesses get a two-cycle ERROR response and never reach
// the SRAM.
module ahb_sram_subordinate #(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    WORD_WIDTH      = 32,
  parameter int                    LOG2_MEM_DEPTH  = 8,
  parameter int                    MEM_DEPTH_WORDS = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
  parameter int                    WAIT_STATES     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [WORD_WIDTH-1:0] HWDATA,
  input  logic [3:0]            HWSTRB,
  input  logic                  HREADY,
  output logic [WORD_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic                  HEXOKAY
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_LAST = 3'd2;
  localparam logic [2:0] S_ERR1 = 3'd3;
  localparam logic [2:0] S_ERR2 = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_DEPTH_WORDS * 4);
  localparam logic [2:0]            CNT_INIT  = 3'(WAIT_STATES - 1);

  // Byte lanes that the transfer size and address may touch.
  function automatic logic [3:0] size_mask(input logic [1:0] size, input logic [1:0] alo);
    logic [3:0] m;
    case (size)
      2'b00:   m = 4'b0001 << alo;
      2'b01:   m = 4'b0011 << alo;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  logic [2:0]                state_q, state_d;
  logic [2:0]                cnt_q, cnt_d;
  logic [LOG2_MEM_DEPTH-1:0] word_q, word_d;
  logic                      write_q, write_d;
  logic [1:0]                size_q, size_d;
  logic [1:0]                alo_q, alo_d;
  logic [WORD_WIDTH-1:0]     hrdata_q, hrdata_d;
  logic                      hreadyout_q, hreadyout_d;
  logic                      hresp_q, hresp_d;

  logic [WORD_WIDTH-1:0]     mem_q [MEM_DEPTH_WORDS];

  logic                      accept_s;
  logic                      illegal_s;
  logic                      take_s;
  logic                      commit_s;
  logic [3:0]                lane_en_s;
  logic [ADDR_WIDTH-1:0]     offset_s;
  logic                      unused_s;

  assign accept_s  = HSEL & HREADY & HTRANS[1];
  assign offset_s  = HADDR - BASE_ADDR;
  // An address below BASE_ADDR wraps to a large offset, so the range check also rejects it.
  assign illegal_s = (offset_s >= MEM_BYTES)
                   | (HSIZE > 3'b010)
                   | ((HSIZE == 3'b001) & HADDR[0])
                   | ((HSIZE == 3'b010) & (HADDR[1:0] != 2'b00));

  // The write commits on the edge that ends LAST. The SRAM is never touched while in reset.
  assign commit_s  = (state_q == S_LAST) & write_q & ~rst;
  assign lane_en_s = HWSTRB & size_mask(size_q, alo_q);

  // HBURST is deliberately ignored and BUSY is treated like IDLE.
  assign unused_s  = ^{HTRANS[0], HBURST};

  assign HRDATA    = hrdata_q;
  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HEXOKAY   = 1'b0;

  // Next-state, access-capture and read-data logic for the transfer FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    write_d  = write_q;
    size_d   = size_q;
    alo_d    = alo_q;
    hrdata_d = hrdata_q;
    take_s   = 1'b0;

    case (state_q)
      S_IDLE, S_LAST, S_ERR2: begin
        if (accept_s) begin
          take_s  = 1'b1;
          state_d = illegal_s ? S_ERR1 : S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = S_LAST;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase

    if (take_s) begin
      word_d  = offset_s[LOG2_MEM_DEPTH+1:2];
      write_d = HWRITE;
      size_d  = HSIZE[1:0];
      alo_d   = HADDR[1:0];
      cnt_d   = CNT_INIT;
    end else begin
      cnt_d   = cnt_d;
    end

    // The read samples the SRAM on the last wait edge. A write to the same word
    // in the previous data phase has already committed by then.
    if ((state_q == S_WAIT) && (cnt_q == 3'd0) && !write_q) begin
      hrdata_d = mem_q[word_q];
    end else begin
      hrdata_d = hrdata_d;
    end

    hreadyout_d = (state_d == S_IDLE) || (state_d == S_LAST) || (state_d == S_ERR2);
    hresp_d     = (state_d == S_ERR1) || (state_d == S_ERR2);
  end

  // FSM, captured access and registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      word_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= 2'b00;
      alo_q       <= 2'b00;
      hrdata_q    <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      write_q     <= write_d;
      size_q      <= size_d;
      alo_q       <= alo_d;
      hrdata_q    <= hrdata_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  // SRAM byte-lane write port. The array is not reset, so its contents survive reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (commit_s && lane_en_s[k]) begin
        mem_q[word_q][8*k +: 8] <= HWDATA[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// Directed self-checking bench for ahb_sram_subordinate. Each transfer pushes
// its expected response onto a scoreboard queue, and the entry is popped and
// compared when the data phase completes.
module tb_ahb_sram_subordinate;

  localparam int WS = 1;

  logic        clk;
  logic        rst;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic [3:0]  HWSTRB;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic        HEXOKAY;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        chk_rd;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Single-subordinate bus: the mux ready is this subordinate's ready.
  assign HREADY = HREADYOUT;

  ahb_sram_subordinate #(
    .ADDR_WIDTH(32), .WORD_WIDTH(32), .LOG2_MEM_DEPTH(8), .MEM_DEPTH_WORDS(256),
    .BASE_ADDR(32'h0), .WAIT_STATES(WS)
  ) dut (
    .clk(clk), .rst(rst), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HWSTRB(HWSTRB), .HREADY(HREADY),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HEXOKAY(HEXOKAY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one address phase, then run its data phase to completion.
  // The call returns inside the final data-phase cycle, so the next call
  // issues its address phase in that same cycle (a pipelined transfer).
  task automatic xfer(input string tag, input logic [31:0] addr, input logic wr,
                      input logic [2:0] size, input logic [31:0] wdata, input logic [3:0] strb,
                      input logic [31:0] exp_rd, input logic chk_rd, input logic exp_err);
    exp_t e;
    int   waits;
    logic first_ready;
    logic first_resp;
    sb.push_back('{tag, exp_rd, chk_rd, exp_err});
    HSEL = 1'b1; HADDR = addr; HTRANS = 2'b10; HWRITE = wr; HSIZE = size;
    tick();
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wdata; HWSTRB = strb;
    first_ready = HREADYOUT;
    first_resp  = HRESP;
    waits = 0;
    while (!HREADYOUT && waits < 20) begin
      waits++;
      tick();
    end
    e = sb.pop_front();
    chk({e.tag, "_waits"}, 32'(waits), e.err ? 32'd1 : 32'(WS));
    chk({e.tag, "_ready1"}, {31'd0, first_ready}, 32'd0);
    chk({e.tag, "_resp1"}, {31'd0, first_resp}, {31'd0, e.err});
    chk({e.tag, "_respN"}, {31'd0, HRESP}, {31'd0, e.err});
    if (e.chk_rd) chk({e.tag, "_rdata"}, HRDATA, e.rdata);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; HSEL = 1'b0; HADDR = 32'h0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'b010; HBURST = 3'b000; HWDATA = 32'h0; HWSTRB = 4'h0;

    // 1: reset held for two cycles.
    tick(); tick();
    chk("rst_ready", {31'd0, HREADYOUT}, 32'd1);
    chk("rst_resp", {31'd0, HRESP}, 32'd0);
    chk("rst_rdata", HRDATA, 32'h0);
    chk("rst_exokay", {31'd0, HEXOKAY}, 32'd0);
    rst = 1'b0;
    tick();

    // 2: word write, then word read back.
    xfer("wr10", 32'h10, 1'b1, 3'b010, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1'b0);
    xfer("rd10", 32'h10, 1'b0, 3'b010, 32'h0, 4'h0, 32'hDEADBEEF, 1'b1, 1'b0);

    // 3: byte write to lane 1. HRDATA must hold the last read value during the write.
    xfer("wrb11", 32'h11, 1'b1, 3'b000, 32'h0000AA00, 4'b0010, 32'h0, 1'b0, 1'b0);
    chk("hold_wr", HRDATA, 32'hDEADBEEF);
    xfer("rd10b", 32'h10, 1'b0, 3'b010, 32'h0, 4'h0, 32'hDEADAAEF, 1'b1, 1'b0);

    // Size mask limits the lanes written even when all strobes are set.
    xfer("wr30", 32'h30, 1'b1, 3'b010, 32'h11223344, 4'hF, 32'h0, 1'b0, 1'b0);
    xfer("wrb31", 32'h31, 1'b1, 3'b000, 32'h55555555, 4'hF, 32'h0, 1'b0, 1'b0);
    xfer("wrh32", 32'h32, 1'b1, 3'b001, 32'h99887766, 4'hF, 32'h0, 1'b0, 1'b0);
    xfer("rd30", 32'h30, 1'b0, 3'b010, 32'h0, 4'h0, 32'h99885544, 1'b1, 1'b0);

    // 4: a write followed by a read of the same word, issued in the write's data phase.
    xfer("wr20", 32'h20, 1'b1, 3'b010, 32'h12345678, 4'hF, 32'h0, 1'b0, 1'b0);
    xfer("rd20", 32'h20, 1'b0, 3'b010, 32'h0, 4'h0, 32'h12345678, 1'b1, 1'b0);

    // Last legal word, and word 0 as a guard against address aliasing.
    xfer("wr3fc", 32'h3FC, 1'b1, 3'b010, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0, 1'b0);
    xfer("wr00", 32'h0, 1'b1, 3'b010, 32'h01020304, 4'hF, 32'h0, 1'b0, 1'b0);
    xfer("rd3fc", 32'h3FC, 1'b0, 3'b010, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b1, 1'b0);

    // 5: illegal accesses give ERROR and leave the SRAM unchanged.
    xfer("rd400", 32'h400, 1'b0, 3'b010, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1);
    chk("hold_err", HRDATA, 32'hA5A5A5A5);
    xfer("rdh3", 32'h3, 1'b0, 3'b001, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1);
    xfer("wr400", 32'h400, 1'b1, 3'b010, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0, 1'b1);
    xfer("wrh11", 32'h11, 1'b1, 3'b001, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0, 1'b1);
    xfer("wrw12", 32'h12, 1'b1, 3'b010, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0, 1'b1);
    xfer("wrsz3", 32'h10, 1'b1, 3'b011, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0, 1'b1);
    xfer("rd00", 32'h0, 1'b0, 3'b010, 32'h0, 4'h0, 32'h01020304, 1'b1, 1'b0);
    xfer("rd10c", 32'h10, 1'b0, 3'b010, 32'h0, 4'h0, 32'hDEADAAEF, 1'b1, 1'b0);

    // 6: IDLE or BUSY with HSEL=1, and NONSEQ with HSEL=0, are all zero-wait OKAY.
    HSEL = 1'b1; HTRANS = 2'b00; HADDR = 32'h10;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("idle_ready%0d", i), {31'd0, HREADYOUT}, 32'd1);
      chk($sformatf("idle_resp%0d", i), {31'd0, HRESP}, 32'd0);
    end
    HTRANS = 2'b01;
    tick();
    chk("busy_ready", {31'd0, HREADYOUT}, 32'd1);
    HSEL = 1'b0; HTRANS = 2'b10;
    tick();
    chk("nosel_ready", {31'd0, HREADYOUT}, 32'd1);
    chk("nosel_resp", {31'd0, HRESP}, 32'd0);

    // Reset during a write's wait state: back to IDLE next cycle and the write is dropped.
    HSEL = 1'b1; HADDR = 32'h10; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'b010;
    tick();
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'hCAFEF00D; HWSTRB = 4'hF;
    chk("wait_ready", {31'd0, HREADYOUT}, 32'd0);
    rst = 1'b1;
    tick();
    chk("rstw_ready", {31'd0, HREADYOUT}, 32'd1);
    chk("rstw_resp", {31'd0, HRESP}, 32'd0);
    chk("rstw_rdata", HRDATA, 32'h0);
    rst = 1'b0;
    tick();
    xfer("rd10d", 32'h10, 1'b0, 3'b010, 32'h0, 4'h0, 32'hDEADAAEF, 1'b1, 1'b0);
    HSEL = 1'b0; HTRANS = 2'b00;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
